// File: rtl/countdown_timer.sv
// mm:ss countdown timer driven by a 1 Hz strobe and debounced button pulses.
// Counts down from a user-set time to 00:00, then holds an alarm for ALARM_SECS ticks.
module countdown_timer #(
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en1hz,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       minup,
    input  logic       secup,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic       done
);

    localparam logic [5:0] LP_ALARM_SECS = 6'(ALARM_SECS);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] mt;
        logic [3:0] mo;
        logic [2:0] st;
        logic [3:0] so;
    } mmss_t;

    state_t     r_state;
    state_t     w_state_nxt;
    mmss_t      r_time;
    mmss_t      w_time_nxt;
    logic [5:0] r_tick;
    logic [5:0] w_tick_nxt;
    logic       r_running;
    logic       r_alarm;
    logic       r_done;
    logic       w_running_nxt;
    logic       w_alarm_nxt;
    logic       w_done_nxt;
    logic       w_zero;
    logic       w_one;

    // Two-digit BCD increment over 00..59, wrapping to 00 with no carry out.
    function automatic logic [6:0] bcd60_inc(input logic [6:0] v);
        logic [2:0] t;
        logic [3:0] o;
        t = v[6:4];
        o = v[3:0];
        if (o < 4'd9)
            return {t, o + 4'd1};
        else if (t < 3'd5)
            return {t + 3'd1, 4'd0};
        else
            return 7'd0;
    endfunction

    // Full mm:ss BCD decrement with ripple borrow; never called at 00:00.
    function automatic mmss_t mmss_dec(input mmss_t v);
        mmss_t d;
        d = v;
        if (v.so != 4'd0) begin
            d.so = v.so - 4'd1;
        end else begin
            d.so = 4'd9;
            if (v.st != 3'd0) begin
                d.st = v.st - 3'd1;
            end else begin
                d.st = 3'd5;
                if (v.mo != 4'd0) begin
                    d.mo = v.mo - 4'd1;
                end else begin
                    d.mo = 4'd9;
                    d.mt = (v.mt != 3'd0) ? v.mt - 3'd1 : 3'd0;
                end
            end
        end
        return d;
    endfunction

    assign w_zero = (r_time == mmss_t'(14'd0));
    assign w_one  = (r_time == mmss_t'(14'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SET;
            r_time    <= mmss_t'(14'd0);
            r_tick    <= 6'd0;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_time    <= w_time_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= w_running_nxt;
            r_alarm   <= w_alarm_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Each state tests inputs in priority order clr > start_stop > minup/secup > en1hz.
    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_tick_nxt  = r_tick;
        case (r_state)
            ST_SET: begin
                if (clr) begin
                    w_time_nxt = mmss_t'(14'd0);
                end else if (start_stop) begin
                    if (!w_zero)
                        w_state_nxt = ST_RUN;
                end else begin
                    if (minup)
                        {w_time_nxt.mt, w_time_nxt.mo} = bcd60_inc({r_time.mt, r_time.mo});
                    if (secup)
                        {w_time_nxt.st, w_time_nxt.so} = bcd60_inc({r_time.st, r_time.so});
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_state_nxt = ST_SET;
                    w_time_nxt  = mmss_t'(14'd0);
                end else if (start_stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (en1hz) begin
                    w_time_nxt = mmss_dec(r_time);
                    if (w_one) begin
                        w_state_nxt = ST_ALARM;
                        w_tick_nxt  = 6'd0;
                    end
                end
            end
            ST_PAUSE: begin
                if (clr) begin
                    w_state_nxt = ST_SET;
                    w_time_nxt  = mmss_t'(14'd0);
                end else if (start_stop) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ALARM: begin
                w_time_nxt = mmss_t'(14'd0);
                if (clr || start_stop) begin
                    w_state_nxt = ST_SET;
                    w_tick_nxt  = 6'd0;
                end else if (en1hz) begin
                    if (r_tick + 6'd1 >= LP_ALARM_SECS) begin
                        w_state_nxt = ST_SET;
                        w_tick_nxt  = 6'd0;
                    end else begin
                        w_tick_nxt = r_tick + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SET;
                w_time_nxt  = mmss_t'(14'd0);
                w_tick_nxt  = 6'd0;
            end
        endcase
    end

    // Status flags are decoded from the next state so they register alongside it.
    always_comb begin
        w_running_nxt = (w_state_nxt == ST_RUN);
        w_alarm_nxt   = (w_state_nxt == ST_ALARM);
        w_done_nxt    = (w_state_nxt == ST_ALARM) && (r_state != ST_ALARM);
    end

    assign min_tens = r_time.mt;
    assign min_ones = r_time.mo;
    assign sec_tens = r_time.st;
    assign sec_ones = r_time.so;
    assign running  = r_running;
    assign alarm    = r_alarm;
    assign done     = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: the driver queues expected display/status
// values, a negedge monitor pops and compares them on the cycle they should appear.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en1hz = 1'b0;
    logic       start_stop = 1'b0;
    logic       clr = 1'b0;
    logic       minup = 1'b0;
    logic       secup = 1'b0;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       alarm;
    logic       done;

    localparam logic [5:0] NONE = 6'd0;
    localparam logic [5:0] EN   = 6'd1;
    localparam logic [5:0] SU   = 6'd2;
    localparam logic [5:0] MU   = 6'd4;
    localparam logic [5:0] CL   = 6'd8;
    localparam logic [5:0] SS   = 6'd16;
    localparam logic [5:0] RS   = 6'd32;

    typedef struct {
        string       name;
        logic [15:0] t;
        logic        run;
        logic        alm;
        logic        dn;
        int          tgt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    logic [15:0] act;

    countdown_timer #(.ALARM_SECS(10)) dut (
        .clk(clk), .rst(rst), .en1hz(en1hz), .start_stop(start_stop),
        .clr(clr), .minup(minup), .secup(secup),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .alarm(alarm), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the front entry is due on the negedge following its driving posedge.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].tgt <= cyc) begin
            e = q.pop_front();
            act = {1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};
            n_tot = n_tot + 1;
            if (e.tgt != cyc)
                $display("FAIL %s: check missed at cycle %0d, required cycle %0d", e.name, cyc, e.tgt);
            else if (act !== e.t || running !== e.run || alarm !== e.alm || done !== e.dn)
                $display("FAIL %s: got %h run=%b alarm=%b done=%b, expected %h run=%b alarm=%b done=%b",
                         e.name, act, running, alarm, done, e.t, e.run, e.alm, e.dn);
            else
                n_pass = n_pass + 1;
        end
    end

    task automatic drv(input logic [5:0] v);
        @(negedge clk);
        {rst, start_stop, clr, minup, secup, en1hz} = v;
    endtask

    task automatic drvn(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) drv(v);
    endtask

    task automatic expect_out(input string name, input logic [15:0] t,
                              input logic run, input logic alm, input logic dn);
        exp_t x;
        x.name = name; x.t = t; x.run = run; x.alm = alm; x.dn = dn; x.tgt = cyc + 1;
        q.push_back(x);
    endtask

    initial begin
        // 1: reset and setting with wrap
        drv(RS);          expect_out("reset", 16'h0000, 0, 0, 0);
        drvn(SU, 3);
        drv(MU);
        drv(MU);          expect_out("set_0203", 16'h0203, 0, 0, 0);
        drvn(SU, 56);     expect_out("set_0259", 16'h0259, 0, 0, 0);
        drv(SU);          expect_out("sec_wrap", 16'h0200, 0, 0, 0);
        drv(CL);          expect_out("set_clr", 16'h0000, 0, 0, 0);
        drv(MU | SU);     expect_out("set_both", 16'h0101, 0, 0, 0);
        drv(CL);
        // 2: run 01:00 down to alarm
        drv(MU);
        drv(SS);          expect_out("run_start", 16'h0100, 1, 0, 0);
        drv(EN);          expect_out("dec_0059", 16'h0059, 1, 0, 0);
        drvn(EN, 58);     expect_out("dec_0001", 16'h0001, 1, 0, 0);
        drv(EN);          expect_out("alarm_entry", 16'h0000, 0, 1, 1);
        drv(NONE);        expect_out("done_pulse", 16'h0000, 0, 1, 0);
        // 3: alarm timeout, early acknowledge, counter cleared
        drvn(EN, 9);      expect_out("alarm_tick9", 16'h0000, 0, 1, 0);
        drv(EN);          expect_out("alarm_tick10", 16'h0000, 0, 0, 0);
        drv(SU);          expect_out("back_in_set", 16'h0001, 0, 0, 0);
        drv(SS);          expect_out("run_0001", 16'h0001, 1, 0, 0);
        drv(EN);          expect_out("alarm2_entry", 16'h0000, 0, 1, 1);
        drvn(EN, 2);      expect_out("alarm2_tick2", 16'h0000, 0, 1, 0);
        drv(SS);          expect_out("alarm_ack", 16'h0000, 0, 0, 0);
        drv(SU);
        drv(SS);
        drv(EN);          expect_out("alarm3_entry", 16'h0000, 0, 1, 1);
        drvn(EN, 9);      expect_out("alarm3_tick9", 16'h0000, 0, 1, 0);
        drv(EN);          expect_out("alarm3_tick10", 16'h0000, 0, 0, 0);
        // 4: pause and resume
        drvn(SU, 10);     expect_out("set_0010", 16'h0010, 0, 0, 0);
        drv(SS);
        drvn(EN, 3);      expect_out("dec_0007", 16'h0007, 1, 0, 0);
        drv(SS | EN);     expect_out("pause_drop", 16'h0007, 0, 0, 0);
        drvn(EN, 5);      expect_out("pause_hold", 16'h0007, 0, 0, 0);
        drv(MU | SU);     expect_out("pause_noset", 16'h0007, 0, 0, 0);
        drv(SS);          expect_out("resume", 16'h0007, 1, 0, 0);
        drv(EN);          expect_out("dec_0006", 16'h0006, 1, 0, 0);
        drv(CL);          expect_out("run_clr", 16'h0000, 0, 0, 0);
        // 5: start at zero ignored, set ignored in RUN, borrows
        drv(SS);          expect_out("start_zero", 16'h0000, 0, 0, 0);
        drvn(MU, 12);
        drvn(SU, 34);     expect_out("set_1234", 16'h1234, 0, 0, 0);
        drv(SS);
        drv(MU);
        drv(SU);
        drv(MU | SU);     expect_out("run_noset", 16'h1234, 1, 0, 0);
        drv(EN);          expect_out("dec_1233", 16'h1233, 1, 0, 0);
        drv(CL);          expect_out("clr_1233", 16'h0000, 0, 0, 0);
        drvn(MU, 10);
        drv(SS);
        drv(EN);          expect_out("borrow_0959", 16'h0959, 1, 0, 0);
        drv(EN);          expect_out("dec_0958", 16'h0958, 1, 0, 0);
        drv(CL);
        // 6: reset mid-run
        drvn(MU, 5);
        drv(SS);          expect_out("run_0500", 16'h0500, 1, 0, 0);
        drv(EN);          expect_out("borrow_0459", 16'h0459, 1, 0, 0);
        drv(RS);          expect_out("rst_in_run", 16'h0000, 0, 0, 0);
        drv(SU);
        drv(SS);
        drv(EN);
        drv(RS);          expect_out("rst_in_alarm", 16'h0000, 0, 0, 0);
        drv(NONE);
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d checks left pending, required 0", q.size());
            n_tot = n_tot + q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
mm:ss countdown timer built from the same 1 Hz strobe and debounced button pulses as the up-counting clock. The clock counts up; this block counts down from a user-set time to 00:00, then raises an alarm. Outputs are per-digit BCD fields so the existing 7-segment decoders and display mux drive HEX directly.

Parameters:
ALARM_SECS, 10, number of en1hz ticks the alarm stays asserted before auto-return to SET (1..63)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en1hz  input  1  one-cycle strobe, once per second (from the 1 s counter)
start_stop  input  1  one-cycle debounced button pulse: start/pause/resume/acknowledge
clr  input  1  one-cycle debounced pulse: clear to 00:00 and return to SET
minup  input  1  one-cycle pulse: increment minutes (SET only)
secup  input  1  one-cycle pulse: increment seconds (SET only)
min_tens  output  3  minutes tens digit, 0..5
min_ones  output  4  minutes ones digit, 0..9
sec_tens  output  3  seconds tens digit, 0..5
sec_ones  output  4  seconds ones digit, 0..9
running  output  1  high in RUN
alarm  output  1  high in ALARM
done  output  1  one-cycle pulse on the cycle ALARM is entered

Behaviour:
- Clock: one clock, clk. Reset: rst, synchronous, active-high.
- All outputs registered; effects of an input are visible on the cycle after it is sampled.
- Reset: all digits 0, state SET, running=0, alarm=0, done=0, alarm tick counter 0. rst mid-RUN or mid-ALARM gives the same result.
- States: SET, RUN, PAUSE, ALARM.
- Input priority in every state: clr > start_stop > minup/secup > en1hz.
- SET:
  - secup: seconds +1 BCD, 59->00, no carry into minutes.
  - minup: minutes +1 BCD, 59->00.
  - minup and secup in the same cycle: both apply.
  - start_stop with time != 00:00: go to RUN. With time == 00:00: ignored, stay in SET.
  - clr: digits to 00:00.
  - en1hz: ignored.
- RUN:
  - en1hz decrements once, BCD:
    - sec_ones 0 -> 9 with borrow from sec_tens.
    - sec_tens 0 -> 5 with borrow from minutes.
    - min_ones 0 -> 9 with borrow from min_tens.
  - Decrement reaching 00:00: go to ALARM next cycle; done pulses 1 cycle; alarm=1.
  - start_stop: go to PAUSE. If en1hz arrives in the same cycle, it is dropped (no decrement).
  - minup/secup: ignored.
  - clr: 00:00, go to SET.
- PAUSE:
  - Digits frozen; en1hz, minup, secup ignored.
  - start_stop: resume RUN.
  - clr: 00:00, go to SET.
- ALARM:
  - Digits hold 00:00.
  - Tick counter increments on en1hz. When it reaches ALARM_SECS: go to SET, alarm=0, counter cleared.
  - start_stop or clr: go to SET immediately, alarm=0, counter cleared.
  - minup/secup: ignored.
- Underflow below 00:00 never occurs: decrementing from 00:01 is the only path to zero, and RUN is never entered at 00:00.
- Digit fields never hold non-BCD values. Digits above range (tens > 5, ones > 9) are unreachable.

Test Plan:
1. Reset, then secup x3, minup x2 -> display 02:03, state SET, running=0. Then secup x57 -> 02:00 (wraps, minutes unchanged).
2. Set 01:00, start_stop, apply 1 en1hz -> 00:59, running=1. 59 further en1hz -> 00:00, done high exactly 1 cycle, alarm=1.
3. In ALARM with ALARM_SECS=10 -> alarm stays 1 for 9 en1hz, drops on the 10th, state SET. Repeat and press start_stop after 2 ticks -> alarm=0 next cycle.
4. Set 00:10, RUN, 3 en1hz -> 00:07. start_stop and en1hz in the same cycle -> PAUSE, display 00:07. 5 en1hz -> still 00:07. start_stop, 1 en1hz -> 00:06.
5. In SET at 00:00, start_stop -> stays SET, running=0. In RUN at 12:34, minup/secup -> no change. clr -> 00:00, SET.
6. In RUN at 05:00, assert rst one cycle -> next cycle 00:00, SET, running=0, alarm=0, done=0.
